// File: rtl/stage_phase_accumulator.sv
// Per-slot phase accumulator feeding the waveform stage: 256 time-multiplexed slots,
// two-clock pipeline with read-after-write forwarding and a post-reset clear sweep.
module stage_phase_accumulator #(
   parameter int ALGORITHM_WORD_WIDTH = 16
) (
   input  logic                            i_Clock,
   input  logic                            i_Reset,
   input  logic [7:0]                      i_VoiceOperator,
   input  logic [ALGORITHM_WORD_WIDTH-1:0] i_AlgorithmWord,
   input  logic                            i_NoteOn,
   input  logic signed [15:0]              i_Modulation,
   input  logic                            i_PhaseStepWriteEnable,
   input  logic [7:0]                      i_PhaseStepWriteAddress,
   input  logic [23:0]                     i_PhaseStepWriteValue,
   output logic [7:0]                      o_VoiceOperator,
   output logic [ALGORITHM_WORD_WIDTH-1:0] o_AlgorithmWord,
   output logic                            o_NoteOn,
   output logic signed [16:0]              o_Phase,
   output logic                            o_Ready
);

   localparam logic [0:0] STATE_CLEAR = 1'b0;
   localparam logic [0:0] STATE_RUN   = 1'b1;

   logic [0:0] state_reg;
   logic [7:0] clear_addr_reg;

   logic [23:0] step_ram [0:255];
   logic [23:0] acc_ram  [0:255];
   logic        prev_ram [0:255];

   logic [23:0] step_rd_reg;
   logic [23:0] acc_rd_reg;
   logic        prev_rd_reg;

   logic                            s1_valid_reg;
   logic [7:0]                      s1_slot_reg;
   logic                            s1_gate_reg;
   logic [ALGORITHM_WORD_WIDTH-1:0] s1_alg_reg;
   logic signed [15:0]              s1_mod_reg;
   logic                            fwd_sel_reg;
   logic [23:0]                     fwd_acc_reg;
   logic                            fwd_gate_reg;

   logic        clearing;
   logic [23:0] old_acc;
   logic        old_gate;
   logic        rising;
   logic [23:0] base;
   logic [23:0] new_acc;
   logic [16:0] phase_next;
   logic        ram_we;
   logic [7:0]  ram_waddr;
   logic [23:0] acc_wdata;
   logic        prev_wdata;

   assign clearing = (state_reg == STATE_CLEAR);
   assign o_Ready  = (state_reg == STATE_RUN);

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_reg      <= STATE_CLEAR;
         clear_addr_reg <= 8'd0;
      end else if (clearing) begin
         clear_addr_reg <= clear_addr_reg + 8'd1;
         if (clear_addr_reg == 8'd255) begin
            state_reg <= STATE_RUN;
         end
      end
   end

   // Stage 2 arithmetic; the forwarded value replaces the RAM read when the
   // same slot was in stage 2 on the previous cycle.
   always_comb begin
      old_acc    = fwd_sel_reg ? fwd_acc_reg : acc_rd_reg;
      old_gate   = fwd_sel_reg ? fwd_gate_reg : prev_rd_reg;
      rising     = s1_gate_reg && !old_gate;
      base       = rising ? 24'd0 : old_acc;
      new_acc    = rising ? step_rd_reg : old_acc + step_rd_reg;
      phase_next = {1'b0, base[23:8]} + {s1_mod_reg[15], s1_mod_reg};
   end

   always_comb begin
      ram_we     = 1'b0;
      ram_waddr  = s1_slot_reg;
      acc_wdata  = new_acc;
      prev_wdata = s1_gate_reg;
      if (clearing) begin
         ram_we     = 1'b1;
         ram_waddr  = clear_addr_reg;
         acc_wdata  = 24'd0;
         prev_wdata = 1'b0;
      end else if (s1_valid_reg) begin
         ram_we = 1'b1;
      end
   end

   // Tables hold no reset; the clear sweep initialises accumulators and gates.
   always_ff @(posedge i_Clock) begin
      step_rd_reg <= step_ram[i_VoiceOperator];
      acc_rd_reg  <= acc_ram[i_VoiceOperator];
      prev_rd_reg <= prev_ram[i_VoiceOperator];
      if (i_PhaseStepWriteEnable) begin
         step_ram[i_PhaseStepWriteAddress] <= i_PhaseStepWriteValue;
      end
      if (ram_we) begin
         acc_ram[ram_waddr]  <= acc_wdata;
         prev_ram[ram_waddr] <= prev_wdata;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         s1_valid_reg <= 1'b0;
         s1_slot_reg  <= 8'd0;
         s1_gate_reg  <= 1'b0;
         s1_alg_reg   <= '0;
         s1_mod_reg   <= 16'sd0;
         fwd_sel_reg  <= 1'b0;
         fwd_acc_reg  <= 24'd0;
         fwd_gate_reg <= 1'b0;
      end else begin
         s1_valid_reg <= (state_reg == STATE_RUN);
         s1_slot_reg  <= i_VoiceOperator;
         s1_gate_reg  <= i_NoteOn;
         s1_alg_reg   <= i_AlgorithmWord;
         s1_mod_reg   <= i_Modulation;
         fwd_sel_reg  <= s1_valid_reg && (i_VoiceOperator == s1_slot_reg);
         fwd_acc_reg  <= new_acc;
         fwd_gate_reg <= s1_gate_reg;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         o_VoiceOperator <= 8'd0;
         o_AlgorithmWord <= '0;
         o_NoteOn        <= 1'b0;
         o_Phase         <= 17'sd0;
      end else begin
         o_VoiceOperator <= s1_slot_reg;
         o_AlgorithmWord <= s1_alg_reg;
         o_NoteOn        <= s1_valid_reg && s1_gate_reg;
         o_Phase         <= s1_valid_reg ? phase_next : 17'sd0;
      end
   end

endmodule

// File: tb/tb_stage_phase_accumulator.sv
// Directed bench for stage_phase_accumulator: clear sweep timing, accumulation,
// wrap, forwarding, modulation offsets and reset behaviour.
module tb_stage_phase_accumulator;

   logic               clk;
   logic               rst;
   logic [7:0]         voice_op;
   logic [15:0]        alg;
   logic               note_on;
   logic signed [15:0] modulation;
   logic               step_we;
   logic [7:0]         step_waddr;
   logic [23:0]        step_wval;
   logic [7:0]         out_voice_op;
   logic [15:0]        out_alg;
   logic               out_note_on;
   logic signed [16:0] out_phase;
   logic               out_ready;

   int checks   = 0;
   int failures = 0;
   int ready_at;

   logic [7:0]  wa [0:5];
   logic [23:0] wv [0:5];

   stage_phase_accumulator #(.ALGORITHM_WORD_WIDTH(16)) dut (
      .i_Clock                (clk),
      .i_Reset                (rst),
      .i_VoiceOperator        (voice_op),
      .i_AlgorithmWord        (alg),
      .i_NoteOn               (note_on),
      .i_Modulation           (modulation),
      .i_PhaseStepWriteEnable (step_we),
      .i_PhaseStepWriteAddress(step_waddr),
      .i_PhaseStepWriteValue  (step_wval),
      .o_VoiceOperator        (out_voice_op),
      .o_AlgorithmWord        (out_alg),
      .o_NoteOn               (out_note_on),
      .o_Phase                (out_phase),
      .o_Ready                (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [7:0] s, input logic g, input logic signed [15:0] m);
      voice_op   = s;
      note_on    = g;
      modulation = m;
      alg        = {8'hA5, s};
   endtask

   // Slot 255 has a zero step, so idling on it disturbs nothing.
   task automatic idle();
      set_in(8'd255, 1'b0, 16'sd0);
      step_we = 1'b0;
   endtask

   task automatic write_step(input logic [7:0] a, input logic [23:0] v);
      idle();
      step_we    = 1'b1;
      step_waddr = a;
      step_wval  = v;
      tick();
      step_we = 1'b0;
   endtask

   task automatic pres(input string tag, input logic [7:0] s, input logic g,
                       input logic signed [15:0] m, input logic [16:0] exp);
      set_in(s, g, m);
      tick();
      idle();
      tick();
      chk(tag, {15'd0, out_phase}, {15'd0, exp});
   endtask

   task automatic wait_ready(output int n);
      n = 999;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (out_ready) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      step_we = 1'b0;
      step_waddr = 8'd0;
      step_wval = 24'd0;
      idle();
      wa = '{8'd255, 8'd5, 8'd7, 8'd9, 8'd20, 8'd21};
      wv = '{24'h000000, 24'h000100, 24'hFFFF00, 24'h010000, 24'h001000, 24'hFFF000};
      #1;
      chk("rst_ready", {31'd0, out_ready}, 32'd0);
      chk("rst_phase", {15'd0, out_phase}, 32'd0);
      chk("rst_noteon", {31'd0, out_note_on}, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Clear sweep: slots presented are discarded, step writes still land.
      ready_at = 999;
      for (int k = 1; k <= 300; k++) begin
         set_in(8'd5, 1'b1, 16'sd7);
         if (k <= 6) begin
            step_we    = 1'b1;
            step_waddr = wa[k-1];
            step_wval  = wv[k-1];
         end else begin
            step_we = 1'b0;
         end
         tick();
         if (k == 10) begin
            chk("clear_noteon", {31'd0, out_note_on}, 32'd0);
            chk("clear_phase", {15'd0, out_phase}, 32'd0);
         end
         if (out_ready) begin
            ready_at = k;
            break;
         end
      end
      idle();
      chk("ready_latency", ready_at, 32'd256);

      // Slot 5: step 0x100, one increment of base[23:8] per presentation.
      pres("s5_rise", 8'd5, 1'b1, 16'sd0, 17'h00000);
      chk("s5_noteon", {31'd0, out_note_on}, 32'd1);
      chk("s5_voice", {24'd0, out_voice_op}, 32'd5);
      chk("s5_alg", {16'd0, out_alg}, 32'h0000A505);
      pres("s5_p1", 8'd5, 1'b1, 16'sd0, 17'h00001);
      pres("s5_p2", 8'd5, 1'b1, 16'sd0, 17'h00002);
      pres("s5_release", 8'd5, 1'b0, 16'sd0, 17'h00003);
      chk("s5_rel_noteon", {31'd0, out_note_on}, 32'd0);
      pres("s5_retrig", 8'd5, 1'b1, 16'sd0, 17'h00000);

      // Slot 7: accumulator 0xFFFF00 + 0x200 wraps to 0x000100.
      pres("s7_rise", 8'd7, 1'b1, 16'sd0, 17'h00000);
      write_step(8'd7, 24'h000200);
      pres("s7_top", 8'd7, 1'b1, 16'sd0, 17'h0FFFF);
      pres("s7_wrapped", 8'd7, 1'b1, 16'sd0, 17'h00001);

      // Slot 9 on three consecutive cycles; step rewritten to 0x20000 at the first.
      set_in(8'd9, 1'b1, 16'sd0);
      step_we    = 1'b1;
      step_waddr = 8'd9;
      step_wval  = 24'h020000;
      tick();
      step_we = 1'b0;
      tick();
      chk("s9_fwd0", {15'd0, out_phase}, 32'h00000);
      tick();
      chk("s9_fwd1", {15'd0, out_phase}, 32'h00100);
      idle();
      tick();
      chk("s9_fwd2", {15'd0, out_phase}, 32'h00300);

      // Modulation offsets with two's-complement wrap at 17 bits.
      pres("s20_rise_mod", 8'd20, 1'b1, 16'sd5, 17'h00005);
      pres("s20_negmod", 8'd20, 1'b1, -16'sd32, 17'h1FFF0);
      pres("s21_rise", 8'd21, 1'b1, 16'sd0, 17'h00000);
      pres("s21_posmod", 8'd21, 1'b1, 16'sd32, 17'h10010);
      chk("s21_voice", {24'd0, out_voice_op}, 32'd21);

      // Reset clears outputs without waiting for a clock edge.
      #2;
      rst = 1'b1;
      #1;
      chk("async_phase", {15'd0, out_phase}, 32'd0);
      chk("async_noteon", {31'd0, out_note_on}, 32'd0);
      chk("async_voice", {24'd0, out_voice_op}, 32'd0);
      chk("async_alg", {16'd0, out_alg}, 32'd0);
      chk("async_ready", {31'd0, out_ready}, 32'd0);
      tick();
      rst = 1'b0;

      // Abort the sweep at address 100 and restart it.
      for (int k = 0; k < 100; k++) tick();
      chk("midsweep_ready", {31'd0, out_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(ready_at);
      chk("restart_latency", ready_at, 32'd256);

      // Accumulators cleared; step table survived reset.
      pres("s5_cleared", 8'd5, 1'b0, 16'sd0, 17'h00000);
      pres("s5_step_kept", 8'd5, 1'b0, 16'sd0, 17'h00001);
      pres("s9_cleared", 8'd9, 1'b0, 16'sd0, 17'h00000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
